// File: rtl/conv_window_seq.sv
// conv_window_seq
//   Convolution-engine sequencer. It responds to the top CNN controller's
//   conv_ctrl/weight_dim request. It consumes the row-major pixel stream from
//   the PU mapper, tracks the row/col position, flags every accepted pixel that
//   completes a KxK window, and holds conv_finish after the last pixel.
// Ports
//   clk, nrst        clock (rising edge), asynchronous active-low reset
//   conv_ctrl_i      run/enable level from the top controller
//   conv_clr_i       one-cycle clear; returns the sequencer to IDLE from any state
//   weight_dim_i     kernel dimension K, sampled when a run starts
//   pix_valid_i      pixel offered by the PU mapper
//   pix_ready_o      combinational: a pixel is taken this cycle if valid
//   mac_en_o         registered: a pixel was accepted last cycle
//   out_valid_o      registered: last accepted pixel completed a window
//   out_row_o/col_o  output-map coordinate of the last completed window
//   out_cnt_o        windows emitted since the run started
//   busy_o           sequencer is running
//   conv_finish_o    run complete (held until clear)
//   err_o            illegal K seen at start (held until clear)
module conv_window_seq #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int MAX_K = 31
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             conv_ctrl_i,
  input  logic                             conv_clr_i,
  input  logic [5:0]                       weight_dim_i,
  input  logic                             pix_valid_i,
  output logic                             pix_ready_o,
  output logic                             mac_en_o,
  output logic                             out_valid_o,
  output logic [$clog2(IMG_H)-1:0]         out_row_o,
  output logic [$clog2(IMG_W)-1:0]         out_col_o,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] out_cnt_o,
  output logic                             busy_o,
  output logic                             conv_finish_o,
  output logic                             err_o
);

  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int NW   = $clog2(IMG_W*IMG_H+1);
  localparam int RCW  = (RW > CW) ? RW : CW;
  localparam int CMPW = (RCW > 6) ? RCW : 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        k_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [NW-1:0]     cnt_q;
  logic              err_q;
  logic              mac_q;
  logic              ov_q;
  logic [RW-1:0]     orow_q;
  logic [CW-1:0]     ocol_q;

  logic              accept;
  logic              start;
  logic              k_bad;
  logic              last_pix;
  logic              col_end;
  logic              win;
  logic [31:0]       k_ext;
  logic [CMPW-1:0]   row_ext;
  logic [CMPW-1:0]   col_ext;
  logic [CMPW-1:0]   km1;
  logic [CMPW-1:0]   orow_ext;
  logic [CMPW-1:0]   ocol_ext;

  assign pix_ready_o = (state_q == S_RUN) & conv_ctrl_i & ~conv_clr_i;
  assign accept      = pix_valid_i & pix_ready_o;
  assign start       = (state_q == S_IDLE) & conv_ctrl_i & ~conv_clr_i;

  // K legality is judged in 32 bits so MAX_K and the image size never truncate.
  assign k_ext = {26'd0, weight_dim_i};
  assign k_bad = (k_ext == 32'd0) || (k_ext > 32'(MAX_K)) ||
                 (k_ext > 32'(IMG_W)) || (k_ext > 32'(IMG_H));

  assign col_end  = (col_q == CW'(IMG_W - 1));
  assign last_pix = (row_q == RW'(IMG_H - 1)) && col_end;

  // K >= 1 whenever a pixel can be accepted, so K-1 never wraps.
  assign row_ext  = CMPW'(row_q);
  assign col_ext  = CMPW'(col_q);
  assign km1      = CMPW'(k_q) - CMPW'(1);
  assign win      = (row_ext >= km1) && (col_ext >= km1);
  assign orow_ext = row_ext - km1;
  assign ocol_ext = col_ext - km1;

  always_comb begin
    state_d = state_q;
    if (conv_clr_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (conv_ctrl_i) state_d = k_bad ? S_DONE : S_RUN;
        S_RUN:   if (accept && last_pix) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      k_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      mac_q  <= 1'b0;
      ov_q   <= 1'b0;
      orow_q <= '0;
      ocol_q <= '0;
    end else begin
      // accept is already masked by conv_clr_i, so clear needs no extra gating here.
      mac_q <= accept;
      ov_q  <= accept & win;
      if (conv_clr_i) begin
        k_q   <= '0;
        row_q <= '0;
        col_q <= '0;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (start) begin
          k_q   <= weight_dim_i;
          err_q <= k_bad;
          row_q <= '0;
          col_q <= '0;
          cnt_q <= '0;
        end
        if (accept) begin
          // Position rests at the origin after the last pixel instead of overrunning row.
          if (last_pix) begin
            row_q <= '0;
            col_q <= '0;
          end else if (col_end) begin
            row_q <= row_q + RW'(1);
            col_q <= '0;
          end else begin
            col_q <= col_q + CW'(1);
          end
          if (win) begin
            orow_q <= RW'(orow_ext);
            ocol_q <= CW'(ocol_ext);
            cnt_q  <= cnt_q + NW'(1);
          end
        end
      end
    end
  end

  assign mac_en_o      = mac_q;
  assign out_valid_o   = ov_q;
  assign out_row_o     = orow_q;
  assign out_col_o     = ocol_q;
  assign out_cnt_o     = cnt_q;
  assign busy_o        = (state_q == S_RUN);
  assign conv_finish_o = (state_q == S_DONE);
  assign err_o         = err_q;

endmodule
